apbmst: RTL

APB requester that turns single-word commands from an internal initiator (DMA/control sequencer) into APB3 transfers toward register-file completers such as the rotate block's APB register interface. One transfer is outstanding at a time. The block registers address, write data and control for the whole transfer, applies a PREADY timeout, and returns read data or an error over a valid/ready response channel.

---
 rtl/apbmst.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/apbmst.sv
// APB3 requester: turns single-word initiator commands into one outstanding APB
// transfer, with a PREADY timeout and a valid/ready response channel.
module apbmst #(
   parameter int unsigned RD_LAT  = 1,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        I_PCLK,
   input  logic        I_PRESET_N,
   input  logic        I_CMD_VALID,
   output logic        O_CMD_READY,
   input  logic        I_CMD_WRITE,
   input  logic [31:0] I_CMD_ADDR,
   input  logic [31:0] I_CMD_WDATA,
   output logic        O_RSP_VALID,
   input  logic        I_RSP_READY,
   output logic [31:0] O_RSP_RDATA,
   output logic        O_RSP_ERROR,
   output logic        O_PSEL,
   output logic        O_PENABLE,
   output logic        O_PWRITE,
   output logic [31:0] O_PADDR,
   output logic [31:0] O_PWDATA,
   input  logic [31:0] I_PRDATA,
   input  logic        I_PREADY
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_RDWAIT,
      S_RESP
   } state_t;

   // Counter value seen in the last allowed ACCESS cycle.
   localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        psel_q, psel_d;
   logic        penable_q, penable_d;
   logic        pwrite_q, pwrite_d;
   logic [31:0] paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_error_q, rsp_error_d;
   logic        timeout_hit;
   logic        unused_addr_lsb;

   assign unused_addr_lsb = ^I_CMD_ADDR[1:0];
   assign timeout_hit     = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_error_d = rsp_error_q;
      case (state_q)
         S_IDLE: begin
            if (I_CMD_VALID) begin
               state_d  = S_SETUP;
               pwrite_d = I_CMD_WRITE;
               paddr_d  = {I_CMD_ADDR[31:2], 2'b00};
               pwdata_d = I_CMD_WDATA;
               psel_d   = 1'b1;
               cnt_d    = 8'd0;
            end
         end
         S_SETUP: begin
            state_d   = S_ACCESS;
            penable_d = 1'b1;
         end
         S_ACCESS: begin
            cnt_d = cnt_q + 8'd1;
            // PREADY is checked first so a ready on the last allowed cycle is not an error.
            if (I_PREADY) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               if (pwrite_q) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = 32'd0;
                  rsp_error_d = 1'b0;
               end else if (RD_LAT == 0) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = I_PRDATA;
                  rsp_error_d = 1'b0;
               end else begin
                  state_d = S_RDWAIT;
               end
            end else if (timeout_hit) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = 32'd0;
               rsp_error_d = 1'b1;
            end
         end
         S_RDWAIT: begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = I_PRDATA;
            rsp_error_d = 1'b0;
         end
         S_RESP: begin
            if (I_RSP_READY) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               rsp_error_d = 1'b0;
               rsp_rdata_d = 32'd0;
               cnt_d       = 8'd0;
            end
         end
         default: begin
            state_d   = S_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
      if (!I_PRESET_N) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= 32'd0;
         pwdata_q    <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   assign O_CMD_READY = (state_q == S_IDLE);
   assign O_RSP_VALID = rsp_valid_q;
   assign O_RSP_RDATA = rsp_rdata_q;
   assign O_RSP_ERROR = rsp_error_q;
   assign O_PSEL      = psel_q;
   assign O_PENABLE   = penable_q;
   assign O_PWRITE    = pwrite_q;
   assign O_PADDR     = paddr_q;
   assign O_PWDATA    = pwdata_q;

endmodule
